// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// - imm_src_e     : immediate format select, same encoding as the datapath immSrc
// - OP_*          : RV32I major opcodes used by the test-program loader
// - IMM_*_MIN/MAX : legal signed immediate range for each format
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_S_MIN = -2048;
  localparam int IMM_S_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  // True when a signed immediate lies outside [lo, hi].
  function automatic logic out_of_range(input logic signed [31:0] v, input int lo, input int hi);
    return (v < lo) || (v > hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Bus bundle for instr_encoder.
// Input side : in_valid/in_ready handshake plus decoded fields (immSrc, opcode, rd,
//              funct3, rs1, rs2, imm).
// Output side: out_valid/out_ready handshake plus instr, out_addr, out_err.
// Status     : err_sticky, err_clear, count.
// Handshake rule: a transfer happens on a rising clk edge where valid and ready are
// both high; a producer holding valid keeps its payload stable until that edge, and
// ready never depends combinationally on the same side's valid.
interface instr_encoder_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       immSrc;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic [31:0]      out_addr;
  logic             out_err;
  logic             err_sticky;
  logic             err_clear;
  logic [CNT_W-1:0] count;

  // Driver side (test-program generator / bench).
  modport master (
    output in_valid, immSrc, opcode, rd, funct3, rs1, rs2, imm, out_ready, err_clear,
    input  in_ready, out_valid, instr, out_addr, out_err, err_sticky, count
  );

  // Encoder side.
  modport slave (
    input  in_valid, immSrc, opcode, rd, funct3, rs1, rs2, imm, out_ready, err_clear,
    output in_ready, out_valid, instr, out_addr, out_err, err_sticky, count
  );
endinterface

// File: rtl/instr_pack.sv
// Purely combinational RV32I packer: places the immediate and register fields of an
// I/S/B/J instruction and flags immediates that are out of range or misaligned.
// Ports: imm_src, opcode, rd, funct3, rs1, rs2, imm in; instr, err out.
// An erroneous immediate is still packed from its low bits.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  imm_src,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);
  always_comb begin
    instr = 32'h0;
    err   = 1'b0;
    unique case (imm_src_e'(imm_src))
      IMM_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = out_of_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      IMM_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = out_of_range(imm, IMM_S_MIN, IMM_S_MAX);
      end
      IMM_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = out_of_range(imm, IMM_B_MIN, IMM_B_MAX) | imm[0];
      end
      IMM_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = out_of_range(imm, IMM_J_MIN, IMM_J_MAX) | imm[0];
      end
      default: begin
        instr = 32'h0;
        err   = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder for the test-program loader.
// S1 registers the decoded fields; instr_pack packs them and checks the immediate.
// S2 is the output register holding instr, its address and its error flag.
// Ports: clk, reset (async, active-high), bus (instr_encoder_if.slave).
// Addresses advance by 4 for every word loaded into S2; count advances per output
// handshake; err_sticky records any handed-off erroneous word until err_clear.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic           clk,
  input  logic           reset,
  instr_encoder_if.slave bus
);
  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_src_q, s1_src_d;
  logic [6:0]       s1_opcode_q, s1_opcode_d;
  logic [4:0]       s1_rd_q, s1_rd_d;
  logic [2:0]       s1_funct3_q, s1_funct3_d;
  logic [4:0]       s1_rs1_q, s1_rs1_d;
  logic [4:0]       s1_rs2_q, s1_rs2_d;
  logic [31:0]      s1_imm_q, s1_imm_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q, s2_instr_d;
  logic [31:0]      s2_addr_q, s2_addr_d;
  logic             s2_err_q, s2_err_d;
  logic [31:0]      next_addr_q, next_addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_sticky_q, err_sticky_d;

  logic        in_ready, in_fire, out_fire, s2_load;
  logic [31:0] pack_instr;
  logic        pack_err;

  instr_pack u_pack (
    .imm_src (s1_src_q),
    .opcode  (s1_opcode_q),
    .rd      (s1_rd_q),
    .funct3  (s1_funct3_q),
    .rs1     (s1_rs1_q),
    .rs2     (s1_rs2_q),
    .imm     (s1_imm_q),
    .instr   (pack_instr),
    .err     (pack_err)
  );

  // S1 may refill in the same cycle it drains into S2, so in_ready looks at
  // out_ready (through s2_load) but never at in_valid.
  always_comb begin
    out_fire = s2_valid_q & bus.out_ready;
    s2_load  = s1_valid_q & (~s2_valid_q | bus.out_ready);
    in_ready = ~s1_valid_q | s2_load;
    in_fire  = bus.in_valid & in_ready;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_src_d     = s1_src_q;
    s1_opcode_d  = s1_opcode_q;
    s1_rd_d      = s1_rd_q;
    s1_funct3_d  = s1_funct3_q;
    s1_rs1_d     = s1_rs1_q;
    s1_rs2_d     = s1_rs2_q;
    s1_imm_d     = s1_imm_q;
    s2_valid_d   = s2_valid_q;
    s2_instr_d   = s2_instr_q;
    s2_addr_d    = s2_addr_q;
    s2_err_d     = s2_err_q;
    next_addr_d  = next_addr_q;
    count_d      = count_q;
    err_sticky_d = err_sticky_q;

    if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_src_d    = bus.immSrc;
      s1_opcode_d = bus.opcode;
      s1_rd_d     = bus.rd;
      s1_funct3_d = bus.funct3;
      s1_rs1_d    = bus.rs1;
      s1_rs2_d    = bus.rs2;
      s1_imm_d    = bus.imm;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_instr_d  = pack_instr;
      s2_err_d    = pack_err;
      s2_addr_d   = next_addr_q;
      next_addr_d = next_addr_q + 32'd4;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    if (out_fire) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // A set in the same cycle as a clear must win.
    if (out_fire && s2_err_q) begin
      err_sticky_d = 1'b1;
    end else if (bus.err_clear) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_src_q     <= 2'b00;
      s1_opcode_q  <= 7'h0;
      s1_rd_q      <= 5'h0;
      s1_funct3_q  <= 3'h0;
      s1_rs1_q     <= 5'h0;
      s1_rs2_q     <= 5'h0;
      s1_imm_q     <= 32'h0;
      s2_valid_q   <= 1'b0;
      s2_instr_q   <= 32'h0;
      s2_addr_q    <= BASE_ADDR;
      s2_err_q     <= 1'b0;
      next_addr_q  <= BASE_ADDR;
      count_q      <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_src_q     <= s1_src_d;
      s1_opcode_q  <= s1_opcode_d;
      s1_rd_q      <= s1_rd_d;
      s1_funct3_q  <= s1_funct3_d;
      s1_rs1_q     <= s1_rs1_d;
      s1_rs2_q     <= s1_rs2_d;
      s1_imm_q     <= s1_imm_d;
      s2_valid_q   <= s2_valid_d;
      s2_instr_q   <= s2_instr_d;
      s2_addr_q    <= s2_addr_d;
      s2_err_q     <= s2_err_d;
      next_addr_q  <= next_addr_d;
      count_q      <= count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid_q;
  assign bus.instr      = s2_instr_q;
  assign bus.out_addr   = s2_addr_q;
  assign bus.out_err    = s2_err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed format/error/backpressure/reset steps plus a
// randomized round-trip sweep, checked through an expected-word queue.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int CW = 16;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic [31:0] imm;
    logic [1:0]  src;
  } exp_t;

  logic clk;
  logic reset;
  instr_encoder_if #(.CNT_W(CW)) ifc ();

  instr_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  int n_loaded = 0;
  logic [CW-1:0] exp_count = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_pack(input logic [1:0] src, input logic [6:0] op,
      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    w = {25'h0, op};
    case (src)
      2'b00: begin
        w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0];
      end
      2'b01: begin
        w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
        w[31:25] = imm[11:5];
      end
      2'b10: begin
        w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3; w[19:15] = rs1;
        w[24:20] = rs2; w[30:25] = imm[10:5]; w[31] = imm[12];
      end
      default: begin
        w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11]; w[30:21] = imm[10:1];
        w[31] = imm[20];
      end
    endcase
    return w;
  endfunction

  function automatic logic model_err(input logic [1:0] src, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (src)
      2'b00, 2'b01: return (v < -2048) || (v > 2047);
      2'b10:        return (v < -4096) || (v > 4094) || imm[0];
      default:      return (v < -1048576) || (v > 1048574) || imm[0];
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] src, input logic [31:0] w);
    case (src)
      2'b00:   return {{20{w[31]}}, w[31:20]};
      2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] src, input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err);
    exp_t e;
    bit ok;
    ifc.in_valid = 1'b1; ifc.immSrc = src; ifc.opcode = op; ifc.rd = rd;
    ifc.funct3 = f3; ifc.rs1 = rs1; ifc.rs2 = rs2; ifc.imm = imm;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifc.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept");
    end else begin
      e.instr = exp_instr; e.err = exp_err; e.imm = imm; e.src = src;
      e.addr = BASE + 32'(n_loaded) * 4;
      n_loaded++;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_word observed=%h expected=none", ifc.instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr", ifc.instr, e.instr);
        chk("out_addr", ifc.out_addr, e.addr);
        chk("out_err", {31'h0, ifc.out_err}, {31'h0, e.err});
        chk("count", {16'h0, ifc.count}, {16'h0, exp_count});
        if (!e.err) chk("roundtrip", extract(e.src, ifc.instr), e.imm);
      end
      exp_count = exp_count + 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] r_imm;
    ifc.in_valid = 1'b0; ifc.immSrc = 2'b00; ifc.opcode = 7'h0; ifc.rd = 5'h0;
    ifc.funct3 = 3'h0; ifc.rs1 = 5'h0; ifc.rs2 = 5'h0; ifc.imm = 32'h0;
    ifc.out_ready = 1'b0; ifc.err_clear = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
    chk("rst_instr", ifc.instr, 32'h0);
    chk("rst_out_addr", ifc.out_addr, BASE);
    chk("rst_out_err", {31'h0, ifc.out_err}, 32'h0);
    chk("rst_err_sticky", {31'h0, ifc.err_sticky}, 32'h0);
    chk("rst_count", {16'h0, ifc.count}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'h0, ifc.in_ready}, 32'h1);

    // I-format with latency check
    ifc.out_ready = 1'b1;
    send(2'b00, 7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0293, 1'b0);
    chk("lat_not_yet", {31'h0, ifc.out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("lat_valid", {31'h0, ifc.out_valid}, 32'h1);
    drain();
    chk("count_after_one", {16'h0, ifc.count}, 32'h1);

    // S, B, J formats
    send(2'b01, 7'b0100011, 5'd0, 3'b010, 5'd2, 5'd6, 32'd8, 32'h0061_2423, 1'b0);
    send(2'b10, 7'b1100011, 5'd0, 3'b000, 5'd0, 5'd0, -32'sd4, 32'hFE00_0EE3, 1'b0);
    send(2'b11, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF, 1'b0);
    drain();

    // Errors
    send(2'b00, 7'b0010011, 5'd3, 3'd0, 5'd4, 5'd0, 32'd2048,
         model_pack(2'b00, 7'b0010011, 5'd3, 3'd0, 5'd4, 5'd0, 32'd2048), 1'b1);
    drain();
    chk("sticky_set", {31'h0, ifc.err_sticky}, 32'h1);
    send(2'b10, 7'b1100011, 5'd0, 3'd1, 5'd7, 5'd8, 32'd3,
         model_pack(2'b10, 7'b1100011, 5'd0, 3'd1, 5'd7, 5'd8, 32'd3), 1'b1);
    drain();
    ifc.err_clear = 1'b1;
    @(posedge clk); #1;
    ifc.err_clear = 1'b0;
    chk("sticky_cleared", {31'h0, ifc.err_sticky}, 32'h0);
    ifc.out_ready = 1'b0;
    send(2'b01, 7'b0100011, 5'd0, 3'd2, 5'd1, 5'd2, -32'sd3000,
         model_pack(2'b01, 7'b0100011, 5'd0, 3'd2, 5'd1, 5'd2, -32'sd3000), 1'b1);
    @(posedge clk); #1;
    chk("err_word_held", {31'h0, ifc.out_valid}, 32'h1);
    ifc.err_clear = 1'b1; ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.err_clear = 1'b0;
    chk("sticky_set_wins", {31'h0, ifc.err_sticky}, 32'h1);
    drain();

    // Backpressure: 4 back-to-back inputs while the output is stalled
    ifc.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(2'b00, 7'b0010011, 5'(i + 1), 3'd0, 5'd1, 5'd0, 32'(i * 16),
               model_pack(2'b00, 7'b0010011, 5'(i + 1), 3'd0, 5'd1, 5'd0, 32'(i * 16)), 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_in_ready_low", {31'h0, ifc.in_ready}, 32'h0);
        chk("bp_buffered", 32'(exp_q.size()), 32'd2);
        ifc.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two entries buffered
    ifc.out_ready = 1'b0;
    send(2'b00, 7'b0010011, 5'd9, 3'd0, 5'd0, 5'd0, 32'd1,
         model_pack(2'b00, 7'b0010011, 5'd9, 3'd0, 5'd0, 5'd0, 32'd1), 1'b0);
    send(2'b00, 7'b0010011, 5'd10, 3'd0, 5'd0, 5'd0, 32'd2,
         model_pack(2'b00, 7'b0010011, 5'd10, 3'd0, 5'd0, 5'd0, 32'd2), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
    chk("arst_count", {16'h0, ifc.count}, 32'h0);
    exp_q.delete();
    n_loaded = 0;
    exp_count = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_stale", {31'h0, ifc.out_valid}, 32'h0);
    send(2'b01, 7'b0100011, 5'd0, 3'd0, 5'd3, 5'd4, 32'd12,
         model_pack(2'b01, 7'b0100011, 5'd0, 3'd0, 5'd3, 5'd4, 32'd12), 1'b0);
    drain();

    // Randomized round-trip of legal immediates
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [6:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3;
        case (f)
          0, 1:    r_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          2:       r_imm = 32'($urandom_range(0, 4095)) * 2 - 32'd4096;
          default: r_imm = 32'($urandom_range(0, 1048575)) * 2 - 32'd1048576;
        endcase
        op = 7'($urandom_range(0, 127)); rd = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
        f3 = 3'($urandom_range(0, 7));
        send(2'(f), op, rd, f3, rs1, rs2, r_imm,
             model_pack(2'(f), op, rd, f3, rs1, rs2, r_imm), model_err(2'(f), r_imm));
      end
    end
    drain();
    chk("final_count", {16'h0, ifc.count}, {16'h0, exp_count});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate extraction: takes decoded fields plus a 32-bit signed immediate and packs them into a 32-bit RV32I instruction word.
- Covers I, S, B and J formats, selected by the same immSrc encoding the datapath uses.
- Two-stage valid/ready pipeline; emits each word with a sequential instruction-memory address for the test-program loader.
- Flags immediates that do not fit the format or are misaligned.

Parameters:
BASE_ADDR, 32'h0000_0000, address attached to the first emitted word after reset
CNT_W, 16, width of the emitted-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept input this cycle
immSrc  input  2  00=I, 01=S, 10=B, 11=J
opcode  input  7  instr[6:0]
rd  input  5  destination register (I, J)
funct3  input  3  function field (I, S, B)
rs1  input  5  source register 1 (I, S, B)
rs2  input  5  source register 2 (S, B)
imm  input  32  signed immediate, byte offset for B/J
out_valid  output  1  instr/out_addr/out_err valid
out_ready  input  1  consumer accepts output
instr  output  32  packed instruction
out_addr  output  32  BASE_ADDR + 4*count at emission
out_err  output  1  this word's immediate was out of range or misaligned
err_sticky  output  1  any error since last clear
err_clear  input  1  clears err_sticky
count  output  CNT_W  number of words handed off

Behaviour:
- Reset: all pipeline valids 0; out_valid=0, instr=0, out_addr=BASE_ADDR, out_err=0, err_sticky=0, count=0.
- Reset mid-operation drops all in-flight entries; nothing is emitted from them.
- Handshake:
  - Input transfers on in_valid&in_ready; output transfers on out_valid&out_ready.
  - out_valid, once high, holds instr/out_addr/out_err stable until accepted.
- Pipeline:
  - S1 registers fields and computes err.
  - S2 holds the packed word and is the output register.
  - s2_load = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | s2_load (combinational from out_ready, no comb path from in_valid).
  - Latency: accept at edge N gives out_valid=1 after edge N+1.
  - Full throughput of 1 word/cycle with out_ready held high.
  - Up to 2 entries buffered; order preserved.
- Error rules (err=1 if any holds):
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094] or imm[0]=1.
  - J: imm outside [-1048576, 1048574] or imm[0]=1.
  - An erroneous word is still emitted, packed from the truncated low bits, with out_err=1.
- Packing:
  - I: imm[11:0] rs1 funct3 rd opcode.
  - S: imm[11:5] rs2 rs1 funct3 imm[4:0] opcode.
  - B: imm[12] imm[10:5] rs2 rs1 funct3 imm[4:1] imm[11] opcode.
  - J: imm[20] imm[10:1] imm[11] imm[19:12] rd opcode.
  - Unused fields are ignored.
  - Round-trip: for err=0, extracting the immediate from instr with the same immSrc returns imm exactly.
- Addressing:
  - out_addr is assigned at S2 load as BASE_ADDR + 4*(words loaded into S2 since reset), modulo 2^32.
  - count increments on each output handshake, wraps at 2^CNT_W.
- err_sticky:
  - Sets on an output handshake with out_err=1.
  - err_clear clears it.
  - If set and clear occur in the same cycle, set wins.

Decomposition:
- Shared package: immSrc constants IMM_I/IMM_S/IMM_B/IMM_J; RV32I opcode constants (OP_IMM, LOAD, STORE, BRANCH, JAL, JALR); per-format min/max immediate constants.
- One sub-module is natural: instr_pack, a purely combinational pack + range/alignment check, instantiated in S1 and reusable by the assembler testbench.

Test Plan:
- I: opcode=0010011, rd=5, funct3=0, rs1=0, imm=-1, out_ready=1 -> instr=0xFFF00293, out_err=0, out_addr=BASE_ADDR, out_valid one cycle after accept, count=1 after handshake.
- S: opcode=0100011, funct3=010, rs1=2, rs2=6, imm=8 -> instr=0x00612423. B: opcode=1100011, funct3=000, rs1=rs2=0, imm=-4 -> instr=0xFE000EE3.
- J: opcode=1101111, rd=1, imm=2048 -> instr=0x001000EF. Also randomized round-trip of 1000 legal immediates per format -> extraction equals imm.
- Errors: I imm=2048 -> out_err=1, err_sticky=1. B imm=3 -> out_err=1. err_clear pulsed on the same cycle as a new erroneous handshake -> err_sticky stays 1.
- Backpressure: 4 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted, no loss. Release -> words emitted in order with out_addr BASE, +4, +8, +12.
- Reset asserted asynchronously with 2 entries buffered -> out_valid=0 and count=0 immediately. Next accepted word gets out_addr=BASE_ADDR.
